cfg_logic_element: RTL and testbench
====================================

# cfg_logic_element

- Parametrised, serially configurable logic element: N independent K-input LUT channels.
- Each channel's truth table and output mode (combinational or registered) are loaded through one shared bit-serial configuration chain.
- It generalises the team's fixed gate-level cells (e.g. a 5-input AND-OR cell) into one programmable cell that can replace them.
- Multiple cells cascade via `cfg_out` to form a logic array.

## Interface
Parameters:
- K, 5, inputs per LUT channel (2..6)
- N, 2, number of LUT channels (1..8)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_en  in  1  shift enable for configuration chain
- cfg_in  in  1  serial config data in
- cfg_out  out  1  serial config data out (MSB of chain), for cascading
- cfg_done  out  1  one-cycle pulse: full configuration just completed
- cfg_valid  out  1  high while a complete configuration is held
- ce  in  1  clock enable for registered channel outputs
- in  in  N*K  channel inputs; channel c uses in[c*K +: K]
- z  out  N  channel outputs

## Operation
- Chain width CW = N*(2^K+1).
- Per channel c, the slot at base B = c*(2^K+1) holds:
  - truth table tt_c = cfg[B +: 2^K]
  - mode bit m_c = cfg[B+2^K] (1 = registered)
- Shift when cfg_en=1: cfg <= {cfg[CW-2:0], cfg_in}; cfg_out = cfg[CW-1] at all times.
  - The first bit shifted lands at the MSB.
  - Shift order is therefore: m_(N-1), tt_(N-1) MSB..LSB, m_(N-2), ..., tt_0 LSB.
- Bit counter `cnt`, width clog2(CW):
  - Increments on every cfg_en=1 cycle.
  - When cnt==CW-1 with cfg_en=1: cnt wraps to 0, cfg_valid<=1, cfg_done<=1 for the next cycle only.
- cfg_valid clears on any cfg_en=1 cycle that does not complete the load.
  - A partial load, or a reload, invalidates the configuration.
- cfg_en deasserted mid-load: cnt and cfg hold and the load resumes later; cfg_valid stays 0.
- LUT function: f_c = tt_c[in_c], where in_c = in[c*K +: K] is used as an unsigned index.
- Output gating: active = cfg_valid & ~cfg_en.
  - m_c=0: z[c] = active ? f_c : 0 (combinational).
  - m_c=1: z[c] = q_c.
  - q_c <= f_c only when ce & active; otherwise q_c holds.
- Reset (async) clears everything:
  - cfg=0, cnt=0, cfg_valid=0, cfg_done=0, all q_c=0.
  - Consequently z=0 and cfg_out=0.
- Reset mid-load: all partial bits are lost and loading restarts from cnt=0.

## Timing
- Combinational channel: 0-cycle latency from in to z.
- Registered channel: z updates on the edge after in is sampled with ce=1 (1-cycle latency).
- Config: CW cfg_en cycles, not necessarily consecutive.
  - cfg_valid and cfg_done rise on the edge that shifts the final bit.
  - cfg_done falls on the next edge, even if cfg_en is still 1.
- Simultaneous final shift and ce=1: q does not update, because active=0 in that cycle.
  - q updates from the following cycle onward.
- cfg_out delay is CW cycles (cell-to-cell cascade).

## Structure
- Package `le_pkg`:
  - function `cfg_width(K,N)`
  - localparams for slot width (2^K+1) and mode-bit offset
  - counter width
- Sub-module `lut_slice` (one per channel, generate loop):
  - Inputs: tt, mode, in_c, active, ce, clk, rst.
  - Contains the f_c mux, q_c register and z mux.
- Top level holds the shift register, counter, cfg_valid/cfg_done logic and the slice instances.

## Test plan
- AO311-equivalent load (K=5, N=1, CW=33):
  - Stimulus: shift m=0 then tt=0xFFFFFF80 MSB-first.
  - Expect cfg_done pulse exactly once at the 33rd shift.
  - in=5'b00111 -> z=1.
  - in=5'b00101 -> z=0.
  - in=5'b01000 -> z=1.
- Registered mode, N=2:
  - ch1 m=1 tt=XOR-all, ch0 m=0 tt=AND-all; toggle in with ce=1.
  - Expect z[1] lagging f by exactly 1 cycle, z[0] immediate.
  - With ce=0, expect z[1] to hold.
- Interrupted load:
  - Stop cfg_en after 10 bits, idle 5 cycles, resume.
  - Expect z=0 and cfg_valid=0 throughout the gap.
  - Expect completion after the remaining CW-10 shifts.
- Reload:
  - Start from a valid configuration; assert cfg_en for 1 cycle.
  - Expect cfg_valid=0 and z=0 immediately; registered q holds its old value but is masked only for m=0 channels (z still shows q for m=1).
- Async reset mid-load:
  - Assert rst between edges at cnt=20.
  - Expect z, cfg_out, cfg_valid and cfg_done =0 immediately; the next load needs the full CW shifts.
- Cascade:
  - Chain two cells and shift 2*CW bits.
  - Expect the second cell to receive the first CW bits and cfg_out of cell 1 to equal cfg_in delayed by CW cycles.

Source files
------------

// File: rtl/le_pkg.sv
// le_pkg: shared sizing helpers for the configurable logic element.
//   slot_width(k)   - bits per channel slot: 2^k truth-table bits + 1 mode bit
//   mode_off(k)     - offset of the mode bit inside a slot
//   cfg_width(k,n)  - total configuration chain length
//   cnt_width(k,n)  - width of the chain bit counter
// The localparams give the sizes for the default K=5, N=2 cell.
package le_pkg;

  function automatic int slot_width(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int mode_off(input int k);
    return 1 << k;
  endfunction

  function automatic int cfg_width(input int k, input int n);
    return n * slot_width(k);
  endfunction

  function automatic int cnt_width(input int k, input int n);
    return $clog2(cfg_width(k, n));
  endfunction

  localparam int K_DEF    = 5;
  localparam int N_DEF    = 2;
  localparam int SLOT_W   = slot_width(K_DEF);
  localparam int MODE_OFF = mode_off(K_DEF);
  localparam int CNT_W    = cnt_width(K_DEF, N_DEF);

endpackage

// File: rtl/lut_slice.sv
// lut_slice: one K-input LUT channel.
//   clk, rst  - clock, async active-high reset (clears q)
//   tt        - truth table, bit i is the output for input pattern i
//   mode      - 0: combinational output, 1: registered output
//   in_c      - channel inputs, used as an unsigned index into tt
//   active    - configuration is complete and not being shifted
//   ce        - clock enable for the output register
//   z         - channel output
module lut_slice
  import le_pkg::*;
#(
  parameter int K = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2**K-1:0]   tt,
  input  logic              mode,
  input  logic [K-1:0]      in_c,
  input  logic              active,
  input  logic              ce,
  output logic              z
);

  logic f;
  logic q;

  assign f = tt[in_c];

  // q only samples a fully loaded, stable table; during a load or reload it
  // keeps whatever it last captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               q <= 1'b0;
    else if (ce && active) q <= f;
  end

  // Registered channels show q unconditionally; combinational channels are
  // forced low whenever the table is not trustworthy.
  assign z = mode ? q : (active & f);

endmodule

// File: rtl/cfg_logic_element.sv
// cfg_logic_element: N independent K-input LUT channels loaded through one
// bit-serial configuration chain; cells cascade through cfg_out.
//   clk, rst   - clock, async active-high reset
//   cfg_en     - shift the configuration chain this cycle
//   cfg_in     - serial configuration data in
//   cfg_out    - chain MSB, feeds cfg_in of the next cell
//   cfg_done   - one-cycle pulse after the final bit of a load is shifted
//   cfg_valid  - a complete configuration is held
//   ce         - clock enable for registered channels
//   in         - channel inputs, channel c uses in[c*K +: K]
//   z          - channel outputs
// Chain layout per channel c at base c*(2^K+1): truth table, then mode bit.
module cfg_logic_element
  import le_pkg::*;
#(
  parameter int K = 5,
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_en,
  input  logic           cfg_in,
  output logic           cfg_out,
  output logic           cfg_done,
  output logic           cfg_valid,
  input  logic           ce,
  input  logic [N*K-1:0] in,
  output logic [N-1:0]   z
);

  localparam int SW   = slot_width(K);
  localparam int MO   = mode_off(K);
  localparam int TT_W = 1 << K;
  localparam int CW   = cfg_width(K, N);
  localparam int CNTW = cnt_width(K, N);
  localparam logic [CNTW-1:0] LAST = CNTW'(CW - 1);

  logic [CW-1:0]   cfg;
  logic [CNTW-1:0] cnt;
  logic            last_bit;
  logic            active;

  assign last_bit = cfg_en && (cnt == LAST);

  // Any shift that is not the final one of a load leaves a half-written
  // chain, so cfg_valid follows last_bit on every shifting cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg       <= '0;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_done <= last_bit;
      if (cfg_en) begin
        cfg       <= {cfg[CW-2:0], cfg_in};
        cnt       <= last_bit ? '0 : cnt + 1'b1;
        cfg_valid <= last_bit;
      end
    end
  end

  assign cfg_out = cfg[CW-1];
  assign active  = cfg_valid & ~cfg_en;

  for (genvar c = 0; c < N; c++) begin : g_ch
    lut_slice #(.K(K)) u_slice (
      .clk    (clk),
      .rst    (rst),
      .tt     (cfg[c*SW +: TT_W]),
      .mode   (cfg[c*SW + MO]),
      .in_c   (in[c*K +: K]),
      .active (active),
      .ce     (ce),
      .z      (z[c])
    );
  end

endmodule

// File: tb/tb_cfg_logic_element.sv
// tb_cfg_logic_element: directed vectors for the configurable logic element.
// Cells a and b (K=5, N=1) are chained a.cfg_out -> b.cfg_in; cell c is K=5, N=2.
module tb_cfg_logic_element;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       a_en = 1'b0, a_cfg_in = 1'b0;
  logic [4:0] a_in = '0, b_in = '0;
  logic       a_out, a_done, a_valid;
  logic [0:0] a_z;
  logic       b_out, b_done, b_valid;
  logic [0:0] b_z;
  logic       c_en = 1'b0, c_cfg_in = 1'b0, c_ce = 1'b0;
  logic [9:0] c_in = '0;
  logic       c_out, c_done, c_valid;
  logic [1:0] c_z;

  int nvec = 0;
  int nerr = 0;

  cfg_logic_element #(.K(5), .N(1)) u_a (
    .clk(clk), .rst(rst), .cfg_en(a_en), .cfg_in(a_cfg_in), .cfg_out(a_out),
    .cfg_done(a_done), .cfg_valid(a_valid), .ce(1'b1), .in(a_in), .z(a_z)
  );

  cfg_logic_element #(.K(5), .N(1)) u_b (
    .clk(clk), .rst(rst), .cfg_en(a_en), .cfg_in(a_out), .cfg_out(b_out),
    .cfg_done(b_done), .cfg_valid(b_valid), .ce(1'b1), .in(b_in), .z(b_z)
  );

  cfg_logic_element #(.K(5), .N(2)) u_c (
    .clk(clk), .rst(rst), .cfg_en(c_en), .cfg_in(c_cfg_in), .cfg_out(c_out),
    .cfg_done(c_done), .cfg_valid(c_valid), .ce(c_ce), .in(c_in), .z(c_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic shift_a(input logic b);
    a_en = 1'b1; a_cfg_in = b; tick();
  endtask

  task automatic shift_c(input logic b);
    c_en = 1'b1; c_cfg_in = b; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] ao;
    logic [65:0] cv;
    logic [9:0]  v [4];
    logic [9:0]  prev;
    int          idx;

    ao = {1'b0, 32'hFFFF_FF80};   // AO311: z=1 for any input >= 7

    // reset state
    #3;
    chk("rst_a_z", a_z[0], 1'b0);
    chk("rst_a_out", a_out, 1'b0);
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_a_done", a_done, 1'b0);
    chk("rst_c_z1", c_z[1], 1'b0);
    chk("rst_c_out", c_out, 1'b0);
    #4 rst = 1'b0;

    // AO311 load: done/valid only on the 33rd shift
    for (int i = 1; i <= 33; i++) begin
      shift_a(ao[33-i]);
      chk("ao_done", a_done, i == 33);
      chk("ao_valid", a_valid, i == 33);
    end
    a_en = 1'b0;
    a_in = 5'b00111; #1 chk("ao_in07", a_z[0], 1'b1);
    a_in = 5'b00101; #1 chk("ao_in05", a_z[0], 1'b0);
    a_in = 5'b01000; #1 chk("ao_in08", a_z[0], 1'b1);
    a_in = 5'b00000; #1 chk("ao_in00", a_z[0], 1'b0);
    tick();
    chk("ao_done_fall", a_done, 1'b0);
    chk("ao_valid_hold", a_valid, 1'b1);

    // async reset mid-load at cnt=20
    a_in = 5'b11111;
    for (int i = 1; i <= 20; i++) shift_a(1'b1);
    chk("rm_out_pre", a_out, 1'b1);
    chk("rm_valid_pre", a_valid, 1'b0);
    #2 rst = 1'b1; a_en = 1'b0;
    #1;
    chk("rm_z", a_z[0], 1'b0);
    chk("rm_out", a_out, 1'b0);
    chk("rm_valid", a_valid, 1'b0);
    chk("rm_done", a_done, 1'b0);
    #1 rst = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      shift_a(ao[33-i]);
      chk("rm_reload_valid", a_valid, i == 33);
    end
    a_en = 1'b0;
    #1 chk("rm_reload_z", a_z[0], 1'b1);

    // interrupted load: 10 bits, 5 idle cycles, remaining 23
    for (int i = 1; i <= 10; i++) shift_a(ao[33-i]);
    a_en = 1'b0;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("gap_z", a_z[0], 1'b0);
      chk("gap_valid", a_valid, 1'b0);
    end
    for (int i = 11; i <= 33; i++) begin
      shift_a(ao[33-i]);
      chk("resume_done", a_done, i == 33);
    end
    a_en = 1'b0;
    #1 chk("resume_z1", a_z[0], 1'b1);
    a_in = 5'b00101; #1 chk("resume_z0", a_z[0], 1'b0);

    // registered ch1 (XOR-all), combinational ch0 (AND-all)
    cv = {1'b1, 32'h9669_6996, 1'b0, 32'h8000_0000};
    c_ce = 1'b1;
    c_in = 10'b00001_11111;
    for (int i = 1; i <= 66; i++) begin
      shift_c(cv[66-i]);
      chk("c_done", c_done, i == 66);
    end
    c_en = 1'b0;
    #1;
    chk("c_final_q", c_z[1], 1'b0);   // final-shift edge must not load q
    chk("c_final_z0", c_z[0], 1'b1);
    v[0] = 10'b00011_11110;
    v[1] = 10'b10101_11111;
    v[2] = 10'b01000_00111;
    v[3] = 10'b11100_11111;
    prev = c_in;
    for (int k = 0; k < 4; k++) begin
      tick();
      c_in = v[k];
      #1;
      chk("reg_z1", c_z[1], ^prev[9:5]);
      chk("comb_z0", c_z[0], &v[k][4:0]);
      prev = v[k];
    end
    c_ce = 1'b0;
    c_in = 10'b00000_11111;
    tick();
    tick();
    chk("ce0_hold", c_z[1], ^v[2][9:5]);

    // reload: one cfg_en cycle with ce=1
    c_ce = 1'b1; c_en = 1'b1; c_cfg_in = 1'b0;
    #1;
    chk("reload_z0", c_z[0], 1'b0);
    chk("reload_z1", c_z[1], 1'b1);
    tick();
    c_en = 1'b0;
    #1;
    chk("reload_valid", c_valid, 1'b0);
    chk("reload_done", c_done, 1'b0);
    chk("reload_q_hold", c_z[1], 1'b1);

    // cascade: first 33 bits end up in b, last 33 in a
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    cv = {1'b0, 32'hA5A5_3C3C, ao};
    for (int i = 1; i <= 66; i++) begin
      shift_a(cv[66-i]);
      idx = 98 - i;
      chk("casc_out", a_out, (i >= 33) ? cv[idx] : 1'b0);
    end
    a_en = 1'b0;
    b_in = 5'd3;  #1 chk("casc_b03", b_z[0], 1'b1);
    b_in = 5'd30; #1 chk("casc_b30", b_z[0], 1'b0);
    b_in = 5'd29; #1 chk("casc_b29", b_z[0], 1'b1);
    b_in = 5'd0;  #1 chk("casc_b00", b_z[0], 1'b0);
    a_in = 5'b00111; #1 chk("casc_a07", a_z[0], 1'b1);
    chk("casc_b_valid", b_valid, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
